// File: rtl/mb_fetch_scheduler.sv
// mb_fetch_scheduler: walks one frame of macroblocks in raster order.
// For each MB it holds the extractor enable for FETCH_LAT cycles, then
// presents the settled MB to intra-prediction over valid/ready, with the
// MB coordinates and the top/left neighbour availability flags.
// Optional build macro MB_FETCH_STATS_EN adds a saturating stall_cycles
// counter of PRESENT cycles spent waiting on mb_ready.
module mb_fetch_scheduler #(
  parameter int LENGTH    = 1280,
  parameter int WIDTH     = 720,
  parameter int MB_SIZE_L = 16,
  parameter int MB_SIZE_W = 16,
  parameter int FETCH_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        ext_enable,
  output logic [12:0] mbnumber,
  output logic        mb_valid,
  input  logic        mb_ready,
  output logic [7:0]  mb_x,
  output logic [7:0]  mb_y,
  output logic        top_avail,
  output logic        left_avail,
  output logic        mb_last,
  output logic        busy,
  output logic        frame_done
`ifdef MB_FETCH_STATS_EN
  ,
  output logic [23:0] stall_cycles
`endif
);

  localparam int MBS_X  = LENGTH / MB_SIZE_W;
  localparam int MBS_Y  = WIDTH / MB_SIZE_L;
  localparam int NUM_MB = MBS_X * MBS_Y;

  localparam logic [12:0] LAST_MB = 13'(NUM_MB - 1);
  localparam logic [7:0]  LAST_X  = 8'(MBS_X - 1);
  localparam logic [3:0]  LAST_F  = 4'(FETCH_LAT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  state_t     state;
  logic [3:0] fcnt;

  // Neighbour/last flags follow the registered counters directly.
  assign top_avail  = (mb_y != 8'd0);
  assign left_avail = (mb_x != 8'd0);
  assign mb_last    = (mbnumber == LAST_MB);

  // Frame sequencer; all handshake outputs are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      fcnt       <= '0;
      mbnumber   <= '0;
      mb_x       <= '0;
      mb_y       <= '0;
      ext_enable <= 1'b0;
      mb_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (abort && state != IDLE) begin
        // abort wins over any coincident transfer; frame is dropped silently
        state      <= IDLE;
        fcnt       <= '0;
        mbnumber   <= '0;
        mb_x       <= '0;
        mb_y       <= '0;
        ext_enable <= 1'b0;
        mb_valid   <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state      <= FETCH;
            fcnt       <= '0;
            mbnumber   <= '0;
            mb_x       <= '0;
            mb_y       <= '0;
            ext_enable <= 1'b1;
            busy       <= 1'b1;
          end
          FETCH: begin
            if (fcnt == LAST_F) begin
              fcnt       <= '0;
              state      <= PRESENT;
              ext_enable <= 1'b0;
              mb_valid   <= 1'b1;
            end else begin
              fcnt <= fcnt + 4'd1;
            end
          end
          PRESENT: if (mb_ready) begin
            mb_valid <= 1'b0;
            if (mb_last) begin
              // counters keep the final MB position
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              state      <= FETCH;
              ext_enable <= 1'b1;
              mbnumber   <= mbnumber + 13'd1;
              if (mb_x == LAST_X) begin
                mb_x <= '0;
                mb_y <= mb_y + 8'd1;
              end else begin
                mb_x <= mb_x + 8'd1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef MB_FETCH_STATS_EN
  // Back-pressure counter: restarts with each frame, saturates, holds after DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cycles <= '0;
    else if (state == IDLE && start)
      stall_cycles <= '0;
    else if (state == PRESENT && !mb_ready && stall_cycles != 24'hFFFFFF)
      stall_cycles <= stall_cycles + 24'd1;
  end
`endif

endmodule
